// File: rtl/riscv_mmio_pkg.sv
// Shared types and constants for the memory-mapped peripherals hanging off riscv_mc.
package riscv_mmio_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int unsigned UartTxDataOff = 0;
   localparam int unsigned UartStatusOff = 4;

   localparam int unsigned StFull  = 0;
   localparam int unsigned StEmpty = 1;
   localparam int unsigned StBusy  = 2;
   localparam int unsigned StOvf   = 3;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with wrap-bit pointers; rdata_o presents the head combinationally.
module fifo_sync #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(Depth);
   localparam int unsigned PW = AW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_i) wptr_d = wptr_q + PW'(1);
      if (pop_i)  rptr_d = rptr_q + PW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q[AW-1:0]];
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window, TX FIFO, bit-timing FSM.
module mmio_uart_tx
   import riscv_mmio_pkg::*;
#(
   parameter int unsigned         DataWidth = 32,
   parameter int unsigned         AddrWidth = 10,
   parameter logic [AddrWidth-1:0] BaseAddr = 10'h3F0,
   parameter int unsigned         ClkPerBit = 16,
   parameter int unsigned         FifoDepth = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [AddrWidth-1:0] mem_addr_i,
   input  logic                 mem_we_i,
   input  logic [DataWidth-1:0] mem_wdata_i,
   output logic                 hit_o,
   output logic [DataWidth-1:0] mem_rdata_o,
   output logic                 tx_o,
   output logic                 busy_o
);

   localparam int unsigned BaudW = $clog2(ClkPerBit);

   uart_state_e      state_q, state_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             ovf_q, ovf_d;

   logic       sel_status;
   logic       wr_data, wr_status;
   logic       push, pop;
   logic       fifo_full, fifo_empty;
   logic [7:0] fifo_head;
   logic       baud_wrap;
   logic [DataWidth-1:0] status;
   logic       unused_bits;

   // Address decode: bit 2 picks the register, bits [1:0] are don't-care.
   assign hit_o      = (mem_addr_i[AddrWidth-1:3] == BaseAddr[AddrWidth-1:3]);
   assign sel_status = (mem_addr_i[2] == 1'(UartStatusOff >> 2));
   assign wr_data    = hit_o && mem_we_i && !sel_status;
   assign wr_status  = hit_o && mem_we_i && sel_status;
   assign push       = wr_data && (!fifo_full || pop);
   assign unused_bits = ^{mem_wdata_i, mem_addr_i[1:0]};

   fifo_sync #(
      .Width (8),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .wdata_i (mem_wdata_i[7:0]),
      .pop_i   (pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign baud_wrap = (baud_q == BaudW'(ClkPerBit - 1));

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      ovf_d   = ovf_q;

      if (wr_status)                      ovf_d = 1'b0;
      if (wr_data && fifo_full && !pop)   ovf_d = 1'b1;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_head;
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            baud_d = baud_wrap ? '0 : baud_q + BaudW'(1);
            if (baud_wrap) begin
               tx_d    = shift_q[0];
               state_d = DATA;
            end
         end
         DATA: begin
            baud_d = baud_wrap ? '0 : baud_q + BaudW'(1);
            if (baud_wrap) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  tx_d = shift_q[1];
               end
            end
         end
         STOP: begin
            baud_d = baud_wrap ? '0 : baud_q + BaudW'(1);
            // Next frame starts straight out of the stop bit when data is waiting.
            if (baud_wrap) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_head;
                  bit_d   = '0;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase

      // Overflow must see the final pop decision, so re-evaluate after the FSM.
      ovf_d = ovf_q;
      if (wr_status)                    ovf_d = 1'b0;
      if (wr_data && fifo_full && !pop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
      end
   end

   assign tx_o   = tx_q;
   assign busy_o = (state_q != IDLE) || !fifo_empty;

   assign status      = DataWidth'({ovf_q, busy_o, fifo_empty, fifo_full});
   assign mem_rdata_o = (hit_o && sel_status) ? status : '0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised self-checking bench for mmio_uart_tx against a frame-position reference model.
module tb_mmio_uart_tx;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic        hit;
   logic [31:0] rdata;
   logic        tx;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: position inside the current frame (-1 = idle) plus a queue of pending bytes.
   int         m_pos;
   logic [7:0] m_cur;
   logic [7:0] m_q [$];
   logic       m_ovf;

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .DataWidth (32),
      .AddrWidth (10),
      .BaseAddr  (10'h3F0),
      .ClkPerBit (CPB),
      .FifoDepth (DEPTH)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .mem_addr_i  (addr),
      .mem_we_i    (we),
      .mem_wdata_i (wdata),
      .hit_o       (hit),
      .mem_rdata_o (rdata),
      .tx_o        (tx),
      .busy_o      (busy)
   );

   function automatic logic m_hit(input logic [9:0] a);
      return a[9:3] == 7'h7E;
   endfunction

   function automatic logic exp_tx();
      int b;
      if (m_pos < 0) return 1'b1;
      b = m_pos / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return m_cur[b-1];
   endfunction

   function automatic logic exp_busy();
      return (m_pos >= 0) || (m_q.size() > 0);
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [9:0] a);
      if (!m_hit(a) || !a[2]) return 32'h0;
      return {28'h0, m_ovf, exp_busy(), m_q.size() == 0, m_q.size() == DEPTH};
   endfunction

   task automatic model_reset();
      m_pos = -1;
      m_cur = 8'h00;
      m_q.delete();
      m_ovf = 1'b0;
   endtask

   task automatic model_edge(input logic [9:0] a, input logic w, input logic [31:0] d);
      logic wd, ws, pop, acc;
      wd  = w && m_hit(a) && !a[2];
      ws  = w && m_hit(a) && a[2];
      pop = (m_q.size() > 0) && (m_pos < 0 || m_pos == FRAME - 1);
      acc = wd && (m_q.size() < DEPTH || pop);
      if (wd && !acc) m_ovf = 1'b1;
      if (ws) m_ovf = 1'b0;
      if (pop) begin
         m_cur = m_q.pop_front();
         m_pos = 0;
      end else if (m_pos == FRAME - 1) begin
         m_pos = -1;
      end else if (m_pos >= 0) begin
         m_pos = m_pos + 1;
      end
      if (acc) m_q.push_back(d[7:0]);
   endtask

   task automatic drive(input logic [9:0] a, input logic w, input logic [31:0] d);
      addr  = a;
      we    = w;
      wdata = d;
   endtask

   task automatic drive_idle();
      drive(10'($urandom), 1'b0, $urandom);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(addr, we, wdata);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         drive(10'($urandom), 1'($urandom), $urandom);
         @(negedge clk);
         n_checks++;
         if (tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold cyc %0d: got tx=%b busy=%b, want tx=1 busy=0", i, tx, busy);
         end
      end
      drive(10'h3F4, 1'b0, 32'h0);
      #1;
      n_checks++;
      if (rdata !== 32'h2) begin
         n_fail++;
         $display("FAIL reset_status: got %h, want 00000002", rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset_midframe();
      drive(10'h3F0, 1'b1, $urandom);
      tick();
      drive_idle();
      tick();
      tick();
      n_checks++;
      if (tx !== exp_tx() || tx !== 1'b0) begin
         n_fail++;
         $display("FAIL midframe_start: got tx=%b, want 0", tx);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midframe_reset: got tx=%b busy=%b, want tx=1 busy=0", tx, busy);
      end
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      drive(10'h3F0, 1'b1, 32'hDEADBE55);
      #1;
      n_checks++;
      if (hit !== 1'b1) begin
         n_fail++;
         $display("FAIL single_hit: got %b, want 1", hit);
      end
      tick();
      for (int i = 0; i < 46; i++) begin
         n_checks++;
         if (tx !== exp_tx() || busy !== exp_busy()) begin
            n_fail++;
            $display("FAIL single cyc %0d: got tx=%b busy=%b, want tx=%b busy=%b", i, tx, busy, exp_tx(), exp_busy());
         end
         drive_idle();
         tick();
      end
      n_checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         n_fail++;
         $display("FAIL single_end: got tx=%b busy=%b, want tx=1 busy=0", tx, busy);
      end
   endtask

   task automatic test_back_to_back();
      drive(10'h3F0, 1'b1, 32'h00);
      tick();
      drive(10'h3F0, 1'b1, 32'hFF);
      tick();
      for (int i = 0; i < 2 * FRAME + 6; i++) begin
         n_checks++;
         if (tx !== exp_tx() || busy !== exp_busy()) begin
            n_fail++;
            $display("FAIL b2b cyc %0d: got tx=%b busy=%b, want tx=%b busy=%b", i, tx, busy, exp_tx(), exp_busy());
         end
         drive_idle();
         tick();
      end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 6; i++) begin
         drive(10'h3F0, 1'b1, 32'(i));
         tick();
      end
      drive(10'h3F4, 1'b0, 32'h0);
      #1;
      n_checks++;
      if (rdata !== 32'hD || rdata !== exp_rdata(addr)) begin
         n_fail++;
         $display("FAIL ovf_status: got %h, want 0000000d", rdata);
      end
      for (int i = 0; i < 5 * FRAME + 4; i++) begin
         n_checks++;
         if (tx !== exp_tx() || busy !== exp_busy()) begin
            n_fail++;
            $display("FAIL ovf_drain cyc %0d: got tx=%b busy=%b, want tx=%b busy=%b", i, tx, busy, exp_tx(), exp_busy());
         end
         drive_idle();
         tick();
      end
      drive(10'h3F4, 1'b1, 32'h0);
      tick();
      drive(10'h3F4, 1'b0, 32'h0);
      #1;
      n_checks++;
      if (rdata !== 32'h2 || rdata !== exp_rdata(addr)) begin
         n_fail++;
         $display("FAIL ovf_clear: got %h, want 00000002", rdata);
      end
   endtask

   task automatic test_decode();
      logic [9:0] bad [2];
      bad[0] = 10'h3F8;
      bad[1] = 10'h3EC;
      for (int i = 0; i < 2; i++) begin
         drive(bad[i], 1'b1, 32'hAA);
         #1;
         n_checks++;
         if (hit !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL decode_miss %h: got hit=%b rdata=%h, want hit=0 rdata=0", bad[i], hit, rdata);
         end
         tick();
      end
      drive(10'h3F0, 1'b0, 32'h0);
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++;
         if (tx !== 1'b1 || busy !== 1'b0 || rdata !== 32'h0 || hit !== 1'b1) begin
            n_fail++;
            $display("FAIL decode_idle cyc %0d: got tx=%b busy=%b rdata=%h hit=%b, want 1 0 0 1", i, tx, busy, rdata, hit);
         end
      end
      drive(10'h3F3, 1'b1, 32'h5A);
      tick();
      drive_idle();
      n_checks++;
      if (busy !== 1'b1 || busy !== exp_busy()) begin
         n_fail++;
         $display("FAIL decode_lowbits: got busy=%b, want 1", busy);
      end
      for (int i = 0; i < FRAME + 4; i++) begin
         tick();
         n_checks++;
         if (tx !== exp_tx() || busy !== exp_busy()) begin
            n_fail++;
            $display("FAIL decode_frame cyc %0d: got tx=%b busy=%b, want tx=%b busy=%b", i, tx, busy, exp_tx(), exp_busy());
         end
      end
   endtask

   task automatic test_full_pop();
      int guard;
      drive(10'h3F0, 1'b1, 32'h3C);
      tick();
      drive_idle();
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         drive(10'h3F0, 1'b1, $urandom);
         tick();
      end
      drive_idle();
      guard = 0;
      while (m_pos != FRAME - 1 && guard < 2 * FRAME) begin
         n_checks++;
         if (tx !== exp_tx() || busy !== exp_busy()) begin
            n_fail++;
            $display("FAIL fullpop_wait cyc %0d: got tx=%b busy=%b, want tx=%b busy=%b", guard, tx, busy, exp_tx(), exp_busy());
         end
         tick();
         drive_idle();
         guard++;
      end
      n_checks++;
      if (guard >= 2 * FRAME) begin
         n_fail++;
         $display("FAIL fullpop_timeout: got %0d cycles, want < %0d", guard, 2 * FRAME);
      end
      drive(10'h3F0, 1'b1, 32'hA5);
      tick();
      drive(10'h3F4, 1'b0, 32'h0);
      #1;
      n_checks++;
      if (rdata[3] !== 1'b0 || rdata[0] !== 1'b1 || rdata !== exp_rdata(addr)) begin
         n_fail++;
         $display("FAIL fullpop_status: got %h, want ovf=0 full=1 (%h)", rdata, exp_rdata(addr));
      end
      for (int i = 0; i < (DEPTH + 1) * FRAME + 4; i++) begin
         n_checks++;
         if (tx !== exp_tx() || busy !== exp_busy()) begin
            n_fail++;
            $display("FAIL fullpop_drain cyc %0d: got tx=%b busy=%b, want tx=%b busy=%b", i, tx, busy, exp_tx(), exp_busy());
         end
         drive_idle();
         tick();
      end
   endtask

   task automatic test_random();
      logic [9:0] pick [8];
      logic [9:0] a;
      pick[0] = 10'h3F0; pick[1] = 10'h3F1; pick[2] = 10'h3F2; pick[3] = 10'h3F3;
      pick[4] = 10'h3F4; pick[5] = 10'h3F8; pick[6] = 10'h3EC; pick[7] = 10'h3F0;
      for (int i = 0; i < 900; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 10'($urandom) : pick[$urandom_range(0, 7)];
         drive(a, ($urandom_range(0, 9) < 3), $urandom);
         #1;
         n_checks++;
         if (hit !== m_hit(a) || rdata !== exp_rdata(a)) begin
            n_fail++;
            $display("FAIL rand_read cyc %0d addr %h: got hit=%b rdata=%h, want hit=%b rdata=%h", i, a, hit, rdata, m_hit(a), exp_rdata(a));
         end
         tick();
         n_checks++;
         if (tx !== exp_tx() || busy !== exp_busy()) begin
            n_fail++;
            $display("FAIL rand_line cyc %0d: got tx=%b busy=%b, want tx=%b busy=%b", i, tx, busy, exp_tx(), exp_busy());
         end
      end
   endtask

   initial begin
      drive(10'h0, 1'b0, 32'h0);
      test_reset();
      test_reset_midframe();
      test_single();
      test_back_to_back();
      test_overflow();
      test_decode();
      test_full_pop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
